// File: rtl/burst_sequencer.sv
// Burst trigger sequencer: emits N one-cycle triggers spaced P cycles apart, then a done strobe.
// Optional post-trigger gate stretcher is compiled in with BURST_SEQ_GATE_EN.
module burst_sequencer #(
   parameter int PERIOD_W = 16,
   parameter int COUNT_W  = 8,
   parameter int GATE_LEN = 100
) (
   input  logic                clk_i,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [PERIOD_W-1:0] period_i,
   input  logic [COUNT_W-1:0]  count_i,
   output logic                trig_o,
   output logic                gate_o,
   output logic                busy_o,
   output logic                done_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FIRE = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
   localparam logic [COUNT_W-1:0]  C_ONE = COUNT_W'(1);

   logic [1:0]          state_q, state_d;
   logic [PERIOD_W-1:0] per_q, per_d;
   logic [PERIOD_W-1:0] wait_q, wait_d;
   logic [COUNT_W-1:0]  rem_q, rem_d;
   logic                abort_act;

   assign abort_act = abort_i && (state_q != S_IDLE);

   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      wait_d  = wait_q;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && !abort_i && (count_i != '0)) begin
               per_d   = (period_i == '0) ? P_ONE : period_i;
               rem_d   = count_i;
               state_d = S_FIRE;
            end
         end
         S_FIRE: begin
            if (rem_q != '0) rem_d = rem_q - C_ONE;
            if (rem_q <= C_ONE) begin
               state_d = S_DONE;
            end else if (per_q == P_ONE) begin
               state_d = S_FIRE;
            end else begin
               // FIRE itself is the first cycle of the period
               wait_d  = per_q - P_ONE;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_q <= P_ONE) begin
               wait_d  = '0;
               state_d = S_FIRE;
            end else begin
               wait_d = wait_q - P_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_act) begin
         state_d = S_IDLE;
         wait_d  = '0;
         rem_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         per_q   <= '0;
         wait_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         wait_q  <= wait_d;
         rem_q   <= rem_d;
      end
   end

   // outputs decode straight from the state register, so no input reaches them combinationally
   assign trig_o = (state_q == S_FIRE);
   assign busy_o = (state_q != S_IDLE);
   assign done_o = (state_q == S_DONE);

`ifdef BURST_SEQ_GATE_EN
   localparam int GW = $clog2(GATE_LEN + 1);

   logic [GW-1:0] gate_q;

   // retrigger reloads the full length; abort kills any gate in flight
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         gate_q <= '0;
      end else if (abort_act) begin
         gate_q <= '0;
      end else if (state_q == S_FIRE) begin
         gate_q <= GW'(GATE_LEN);
      end else if (gate_q != '0) begin
         gate_q <= gate_q - GW'(1);
      end
   end

   assign gate_o = (gate_q != '0);
`else
   assign gate_o = 1'b0;
`endif

endmodule

// File: doc/burst_sequencer.md
BURST_SEQUENCER -- requirements
Module: burst_sequencer

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16, width of the trigger-spacing field.
REQ-002 SHALL have parameter COUNT_W, default 8, width of the burst-length field.
REQ-003 SHALL have parameter GATE_LEN, default 100, gate width in clk_i cycles (>=1).
REQ-004 SHALL have port: clk_i  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port: start_i  input  1  burst request, sampled in IDLE only.
REQ-007 SHALL have port: abort_i  input  1  terminate burst.
REQ-008 SHALL have port: period_i  input  PERIOD_W  cycles between triggers.
REQ-009 SHALL have port: count_i  input  COUNT_W  triggers per burst.
REQ-010 SHALL have port: trig_o  output  1  one-cycle trigger strobe.
REQ-011 SHALL have port: gate_o  output  1  widened gate following each trigger.
REQ-012 SHALL have port: busy_o  output  1  burst in progress.
REQ-013 SHALL have port: done_o  output  1  one-cycle completion strobe.

Function
REQ-014 SHALL implement FSM states IDLE, FIRE, WAIT, DONE.
REQ-015 SHALL, in IDLE with start_i=1, abort_i=0 and count_i!=0, latch P=max(period_i,1) and N=count_i, then go to FIRE.
REQ-016 SHALL ignore start_i when count_i=0 (remain IDLE, no strobes) and whenever not in IDLE.
REQ-017 SHALL assert trig_o exactly during each FIRE cycle, the first FIRE one cycle after start acceptance.
REQ-018 SHALL space consecutive trig_o rising edges exactly P cycles apart (P=1 gives back-to-back strobes).
REQ-019 SHALL, after the N-th trigger, enter DONE on the next cycle, assert done_o for that one cycle, then return to IDLE.
REQ-020 SHALL drive busy_o high in FIRE, WAIT and DONE, low in IDLE.
REQ-021 SHALL, on abort_i=1 in any non-IDLE state, go to IDLE next cycle, suppress trig_o and done_o in that cycle, and clear the gate counter.
REQ-022 SHALL give abort_i priority over start_i when both are high in IDLE (start not accepted).
REQ-023 SHALL hold internal period/remaining counters in latched widths; remaining count SHALL not wrap below zero.
REQ-024 SHALL change no output combinationally from any input; all outputs registered.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE and trig_o=0, gate_o=0, busy_o=0, done_o=0, all counters 0, asynchronously.
REQ-026 SHALL, on reset mid-burst, discard the burst with no done_o; first start accepted on the first rising edge with rst_n=1.

Configuration
REQ-027 SHALL compile the gate generator only when macro BURST_SEQ_GATE_EN is defined.
REQ-028 SHALL, with BURST_SEQ_GATE_EN, drive gate_o high for GATE_LEN cycles beginning the cycle after each trig_o; a new trigger during an active gate restarts the count at GATE_LEN.
REQ-029 SHALL, without BURST_SEQ_GATE_EN, tie gate_o to 0 and instantiate no gate counter; all other behaviour unchanged.

Verification
REQ-030 SHALL cover: start with period_i=5, count_i=3 -> trig_o at cycles 1, 6, 11 after acceptance; done_o at 12; busy_o high cycles 1-12.
REQ-031 SHALL cover: period_i=0, count_i=4 -> four consecutive trig_o cycles, done_o on the 5th cycle.
REQ-032 SHALL cover: count_i=0 with start_i=1 -> busy_o, trig_o, done_o stay 0.
REQ-033 SHALL cover: abort_i pulsed after second trigger of period 10, count 5 burst -> no further trig_o, no done_o, busy_o low next cycle, gate_o low next cycle.
REQ-034 SHALL cover: rst_n low mid-burst between clock edges -> all outputs 0 immediately, new burst accepted after release.
REQ-035 SHALL cover, with BURST_SEQ_GATE_EN and GATE_LEN=8: period 5, count 2 -> gate_o high continuously from trig+1 for 5+8 cycles; without macro gate_o always 0.
